ahb_slv_port_sched: RTL and testbench
=====================================

// Module: ahb_slv_port_sched
// PURPOSE
//  Per-slave-port scheduler for the AHB-Lite matrix. Shares one slave port among MST_NUM
//  masters: round-robin address-phase arbitration, burst and HMASTLOCK hold, grant freeze
//  while the slave stalls, and tracking of the data-phase owner for read-data/response
//  return. One instance per slave port; it drives the address mux and the return demux.
// PARAMETERS
//  MST_NUM   3   number of masters sharing the port (>=2)
//  LOCK_EN   1   1: honour lock[]; 0: lock[] ignored, LOCKED state unreachable
// PORTS
//  clk         in   1        clock; all state updates on rising edge
//  rst         in   1        asynchronous, active-high reset
//  req         in   MST_NUM  master m has NONSEQ/SEQ transfer for this slave; held until accepted
//  seq         in   MST_NUM  master m's pending transfer is SEQ (burst continuation)
//  lock        in   MST_NUM  HMASTLOCK of master m
//  hready_s    in   1        slave HREADYOUT; 1 = current data phase completes this cycle
//  addr_gnt    out  MST_NUM  one-hot/zero: master whose address phase is driven to the slave
//  addr_valid  out  1        |(addr_gnt & req): real transfer presented (else IDLE driven)
//  accept      out  MST_NUM  addr_gnt & req & {hready_s}: address phase taken this cycle
//  data_owner  out  MST_NUM  registered one-hot: master owning current data phase
//  data_valid  out  1        registered: a data phase is in progress
// BEHAVIOUR
//  Reset (async, immediate, also mid-transfer): state=FREE, last_ptr=MST_NUM-1,
//   gnt_q=0, stall_q=0, data_owner=0, data_valid=0; addr_gnt/addr_valid/accept=0 while rst=1.
//  States: FREE, LOCKED. owner = last accepted master (last_ptr).
//  Grant select gnt_c (priority order):
//   1. stall_q=1 -> addr_gnt=gnt_q (frozen; no re-arbitration while slave waits).
//   2. LOCKED -> addr_gnt=owner, even if req[owner]=0 (IDLE, addr_valid=0); others blocked.
//   3. req[owner]&seq[owner] -> owner (never switch mid-burst).
//   4. else round-robin: first m with req[m], searching last_ptr+1 .. last_ptr (mod MST_NUM,
//      wrap at MST_NUM-1 -> 0). No req -> addr_gnt=0.
//  gnt_q <= addr_gnt every cycle; stall_q <= addr_valid & ~hready_s.
//  On accept[m] (hready_s=1): last_ptr<=m; data_owner<=onehot(m); data_valid<=1.
//  hready_s=1 with no accept: data_valid<=0, data_owner<=0.
//  hready_s=0: data_owner/data_valid/last_ptr/state hold.
//  FSM (evaluated only when hready_s=1):
//   FREE->LOCKED  : accept[m] & lock[m] & LOCK_EN.
//   LOCKED->FREE  : lock[owner]=0 (accepted unlocked transfer or idle unlocked).
//   LOCKED->LOCKED otherwise; pointer still updates on owner's accepts.
//  Latency: arbitration is combinational (0 cycles req->addr_gnt when port free);
//   data_owner valid the cycle after accept; no bubbles between masters.
//  Simultaneous: owner ending burst (seq=0) competes in RR with last_ptr=owner -> owner has
//   lowest priority; accept and new lock in same cycle -> LOCKED next cycle.
//  Stall with frozen grant whose req drops is illegal on AHB; not checked, grant still frozen.
// TESTING
//  T1 reset: rst=1 with req=3'b111 -> all outputs 0; release, hready_s=1 -> addr_gnt=3'b001,
//   next cycle data_owner=3'b001, data_valid=1.
//  T2 RR: req=3'b111 held, hready_s=1, seq=0 -> addr_gnt sequence 001,010,100,001 (wrap).
//  T3 stall freeze: gnt=001 accepted, hready_s=0 for 3 cycles with req=3'b110 -> addr_gnt=
//   frozen, data_owner=001 stable; hready_s=1 -> 010 accepted.
//  T4 burst: m1 NONSEQ then seq[1]=1 for 3 beats, req[0]=1 throughout -> addr_gnt=010 for
//   4 accepts, then 001.
//  T5 lock: m2 accepted with lock[2]=1, m2 idles 2 cycles (req[2]=0,lock[2]=1), req[0]=1 ->
//   addr_gnt=100, addr_valid=0; lock[2]=0 -> FREE, m0 granted next cycle.
//  T6 reset mid-stall: stall_q=1, data_valid=1, assert rst -> data_valid=0, addr_gnt=0
//   same cycle; after release RR restarts at m0.

Source files
------------

// File: rtl/ahb_slv_port_sched_if.sv
// Bundle of request/grant and data-phase tracking signals between the masters
// sharing one AHB-Lite slave port and that port's scheduler.
//   req/seq/lock : per-master pending transfer, burst continuation, HMASTLOCK
//   hready_s     : slave HREADYOUT
//   addr_gnt/addr_valid/accept : address-phase grant, real transfer, taken
//   data_owner/data_valid      : registered data-phase owner and activity
// Modport "master" is the side presenting requests; "slave" is the scheduler.
interface ahb_slv_port_sched_if #(
  parameter int unsigned MST_NUM = 3
);
  logic [MST_NUM-1:0] req;
  logic [MST_NUM-1:0] seq;
  logic [MST_NUM-1:0] lock;
  logic               hready_s;
  logic [MST_NUM-1:0] addr_gnt;
  logic               addr_valid;
  logic [MST_NUM-1:0] accept;
  logic [MST_NUM-1:0] data_owner;
  logic               data_valid;

  modport master (
    output req, seq, lock, hready_s,
    input  addr_gnt, addr_valid, accept, data_owner, data_valid
  );

  modport slave (
    input  req, seq, lock, hready_s,
    output addr_gnt, addr_valid, accept, data_owner, data_valid
  );
endinterface

// File: rtl/ahb_slv_port_sched.sv
// Per-slave-port scheduler for the AHB-Lite matrix. Round-robin address-phase
// arbitration among MST_NUM masters with burst and HMASTLOCK hold, grant freeze
// while the slave stalls, and tracking of the data-phase owner.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : ahb_slv_port_sched_if.slave (req/seq/lock/hready_s in;
//          addr_gnt/addr_valid/accept combinational out;
//          data_owner/data_valid registered out)
module ahb_slv_port_sched #(
  parameter int unsigned MST_NUM = 3,
  parameter bit          LOCK_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  ahb_slv_port_sched_if.slave     bus
);

  localparam int unsigned PTR_W = (MST_NUM > 1) ? $clog2(MST_NUM) : 1;

  typedef enum logic {FREE, LOCKED} state_t;

  state_t             state_q;
  logic [PTR_W-1:0]   last_ptr_q;
  logic [MST_NUM-1:0] gnt_q;
  logic               stall_q;
  logic [MST_NUM-1:0] data_owner_q;
  logic               data_valid_q;

  logic [MST_NUM-1:0] owner_oh;
  logic [MST_NUM-1:0] rr_gnt;
  logic               rr_found;
  logic [PTR_W-1:0]   rr_idx;
  logic [MST_NUM-1:0] gnt_c;
  logic               addr_valid_c;
  logic [MST_NUM-1:0] accept_c;
  logic [PTR_W-1:0]   acc_idx;

  assign owner_oh = MST_NUM'(1) << last_ptr_q;

  // Round-robin search starting just after the last accepted master.
  always_comb begin
    rr_gnt   = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned k = 1; k <= MST_NUM; k++) begin
      rr_idx = PTR_W'((32'(last_ptr_q) + k) % MST_NUM);
      if (!rr_found && bus.req[rr_idx]) begin
        rr_gnt[rr_idx] = 1'b1;
        rr_found       = 1'b1;
      end
    end
  end

  // Grant priority: stall freeze, lock hold, burst hold, round-robin.
  always_comb begin
    gnt_c = '0;
    if (rst)
      gnt_c = '0;
    else if (stall_q)
      gnt_c = gnt_q;
    else if (LOCK_EN && (state_q == LOCKED))
      gnt_c = owner_oh;
    else if (bus.req[last_ptr_q] && bus.seq[last_ptr_q])
      gnt_c = owner_oh;
    else
      gnt_c = rr_gnt;
  end

  assign addr_valid_c = |(gnt_c & bus.req);
  assign accept_c     = gnt_c & bus.req & {MST_NUM{bus.hready_s}};

  // Index of the accepted master (accept is one-hot or zero).
  always_comb begin
    acc_idx = '0;
    for (int unsigned m = 0; m < MST_NUM; m++) begin
      if (accept_c[m]) acc_idx = PTR_W'(m);
    end
  end

  // Lock FSM, pointer and data-phase tracking; all advance only when the slave is ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FREE;
      last_ptr_q   <= PTR_W'(MST_NUM - 1);
      gnt_q        <= '0;
      stall_q      <= 1'b0;
      data_owner_q <= '0;
      data_valid_q <= 1'b0;
    end else begin
      gnt_q   <= gnt_c;
      stall_q <= addr_valid_c & ~bus.hready_s;
      if (bus.hready_s) begin
        if (|accept_c) begin
          last_ptr_q   <= acc_idx;
          data_owner_q <= accept_c;
          data_valid_q <= 1'b1;
        end else begin
          data_owner_q <= '0;
          data_valid_q <= 1'b0;
        end
        case (state_q)
          FREE:    if (LOCK_EN && |(accept_c & bus.lock)) state_q <= LOCKED;
          LOCKED:  if (!bus.lock[last_ptr_q]) state_q <= FREE;
          default: state_q <= FREE;
        endcase
      end
    end
  end

  assign bus.addr_gnt   = gnt_c;
  assign bus.addr_valid = addr_valid_c;
  assign bus.accept     = accept_c;
  assign bus.data_owner = data_owner_q;
  assign bus.data_valid = data_valid_q;

endmodule

// File: tb/tb_ahb_slv_port_sched.sv
// Bench for ahb_slv_port_sched (MST_NUM=3, LOCK_EN=1). Directed steps drive the
// masters and queue the expected accepts / data-phase owners; a monitor pops
// and compares them whenever the DUT accepts or completes a data phase.
module tb_ahb_slv_port_sched;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [2:0] exp_acc[$];
  logic [2:0] exp_own[$];

  ahb_slv_port_sched_if #(.MST_NUM(3)) bus ();

  ahb_slv_port_sched #(.MST_NUM(3), .LOCK_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  // One address cycle: drive at posedge+1, check grant at negedge, return at next posedge+1.
  task automatic step(input string nm, input logic [2:0] r, input logic [2:0] s,
                      input logic [2:0] l, input logic h, input logic [2:0] eg);
    logic [2:0] av;
    bus.req = r; bus.seq = s; bus.lock = l; bus.hready_s = h;
    if (h && |(eg & r)) begin
      exp_acc.push_back(eg);
      exp_own.push_back(eg);
    end
    @(negedge clk);
    chk({nm, "_gnt"}, bus.addr_gnt, eg);
    av = {2'b00, |(eg & r)};
    chk({nm, "_valid"}, {2'b00, bus.addr_valid}, av);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_data(input string nm, input logic [2:0] own, input logic vld);
    chk({nm, "_owner"}, bus.data_owner, own);
    chk({nm, "_dvalid"}, {2'b00, bus.data_valid}, {2'b00, vld});
  endtask

  // Monitor: compare every accept and every completed data phase against the queues.
  initial begin
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (|bus.accept) begin
          if (exp_acc.size() == 0) begin
            total++; bad++;
            $display("FAIL mon_accept unexpected actual=%b required=none", bus.accept);
          end else begin
            e = exp_acc.pop_front();
            chk("mon_accept", bus.accept, e);
          end
        end
        if (bus.data_valid && bus.hready_s) begin
          if (exp_own.size() == 0) begin
            total++; bad++;
            $display("FAIL mon_owner unexpected actual=%b required=none", bus.data_owner);
          end else begin
            e = exp_own.pop_front();
            chk("mon_owner", bus.data_owner, e);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req = 3'b111; bus.seq = 3'b000; bus.lock = 3'b000; bus.hready_s = 1'b1;

    // T1: outputs quiet under reset even with all masters requesting
    @(negedge clk);
    chk("rst_gnt", bus.addr_gnt, 3'b000);
    chk("rst_valid", {2'b00, bus.addr_valid}, 3'b000);
    chk("rst_accept", bus.accept, 3'b000);
    chk_data("rst", 3'b000, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    step("t1", 3'b111, 3'b000, 3'b000, 1'b1, 3'b001);
    chk_data("t1", 3'b001, 1'b1);

    // T2: round-robin with wrap
    step("t2a", 3'b111, 3'b000, 3'b000, 1'b1, 3'b010);
    step("t2b", 3'b111, 3'b000, 3'b000, 1'b1, 3'b100);
    step("t2c", 3'b111, 3'b000, 3'b000, 1'b1, 3'b001);

    // T3: stall freeze; m0 SEQ during stall must not steal the frozen grant
    step("t3a", 3'b001, 3'b000, 3'b000, 1'b1, 3'b001);
    chk_data("t3a", 3'b001, 1'b1);
    step("t3s1", 3'b110, 3'b000, 3'b000, 1'b0, 3'b010);
    chk_data("t3s1", 3'b001, 1'b1);
    step("t3s2", 3'b111, 3'b001, 3'b000, 1'b0, 3'b010);
    chk_data("t3s2", 3'b001, 1'b1);
    step("t3s3", 3'b111, 3'b001, 3'b000, 1'b0, 3'b010);
    chk_data("t3s3", 3'b001, 1'b1);
    step("t3r", 3'b110, 3'b000, 3'b000, 1'b1, 3'b010);
    chk_data("t3r", 3'b010, 1'b1);

    // T4: m1 burst holds the port against m0, then m0 wins
    step("t4p", 3'b001, 3'b000, 3'b000, 1'b1, 3'b001);
    step("t4n", 3'b011, 3'b000, 3'b000, 1'b1, 3'b010);
    for (int i = 0; i < 3; i++)
      step("t4s", 3'b011, 3'b010, 3'b000, 1'b1, 3'b010);
    step("t4e", 3'b011, 3'b000, 3'b000, 1'b1, 3'b001);

    // T5: locked m2 keeps the port while idle; release hands it to m0
    step("t5a", 3'b100, 3'b000, 3'b100, 1'b1, 3'b100);
    step("t5i1", 3'b001, 3'b000, 3'b100, 1'b1, 3'b100);
    chk_data("t5i1", 3'b000, 1'b0);
    step("t5i2", 3'b001, 3'b000, 3'b100, 1'b1, 3'b100);
    step("t5u", 3'b001, 3'b000, 3'b000, 1'b1, 3'b100);
    step("t5f", 3'b001, 3'b000, 3'b000, 1'b1, 3'b001);

    // T6: reset in the middle of a stall
    step("t6a", 3'b010, 3'b000, 3'b000, 1'b1, 3'b010);
    step("t6s1", 3'b100, 3'b000, 3'b000, 1'b0, 3'b100);
    step("t6s2", 3'b100, 3'b000, 3'b000, 1'b0, 3'b100);
    chk_data("t6pre", 3'b010, 1'b1);
    rst = 1'b1;
    exp_acc.delete();
    exp_own.delete();
    #1;
    chk_data("t6rst", 3'b000, 1'b0);
    chk("t6rst_gnt", bus.addr_gnt, 3'b000);
    chk("t6rst_accept", bus.accept, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    step("t6b", 3'b111, 3'b000, 3'b000, 1'b1, 3'b001);
    step("t6c", 3'b111, 3'b000, 3'b000, 1'b1, 3'b010);
    step("t6d", 3'b000, 3'b000, 3'b000, 1'b1, 3'b000);

    chk("drain_acc", 3'(exp_acc.size()), 3'b000);
    chk("drain_own", 3'(exp_own.size()), 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
